// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch datapath: RUN / ADJ / PAUSED mode FSM, cascaded BCD counting,
// adjust-mode blink masks and a rollover strobe, all synchronous to clkDis.
`timescale 1ns/1ps

module stopwatch_counter (
  input  logic       clkDis,
  input  logic       rst,
  input  logic       pause,
  input  logic       tick1Hz,
  input  logic       tick2Hz,
  input  logic       adj,
  input  logic       sel,
  output logic [2:0] m10,
  output logic [3:0] m1,
  output logic [2:0] s10,
  output logic [3:0] s1,
  output logic [1:0] mode,
  output logic       blankMin,
  output logic       blankSec,
  output logic       wrap
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    ADJ    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  state_t     state, state_n;
  logic       adjM, adjS, selM, selS;
  logic       bp, bp_n;
  logic [2:0] m10_n, s10_n;
  logic [3:0] m1_n, s1_n;
  logic       wrap_n;
  logic       run_inc, adj_inc;

  // Two-stage synchronizers for the raw mode switches.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkDis) begin
    if (rst) begin
      adjM <= 1'b0;
      adjS <= 1'b0;
      selM <= 1'b0;
      selS <= 1'b0;
    end else begin
      adjM <= adj;
      adjS <= adjM;
      selM <= sel;
      selS <= selM;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = RUN;
    if (rst)       state_n = RUN;
    else if (pause) state_n = PAUSED;
    else if (adjS)  state_n = ADJ;
  end

  // Ticks are qualified by the state held during the tick cycle.
  assign run_inc = (state == RUN) && tick1Hz;
  assign adj_inc = (state == ADJ) && tick2Hz;

  always_comb begin
    m10_n  = m10;
    m1_n   = m1;
    s10_n  = s10;
    s1_n   = s1;
    wrap_n = 1'b0;
    if (run_inc || (adj_inc && selS)) begin
      if (s1 >= 4'd9) begin
        s1_n = 4'd0;
        if (s10 >= 3'd5) begin
          s10_n = 3'd0;
          // Only RUN carries seconds into minutes; ADJ wraps the field in place.
          if (run_inc) begin
            if (m1 >= 4'd9) begin
              m1_n = 4'd0;
              if (m10 >= 3'd5) begin
                m10_n  = 3'd0;
                wrap_n = 1'b1;
              end else begin
                m10_n = m10 + 3'd1;
              end
            end else begin
              m1_n = m1 + 4'd1;
            end
          end
        end else begin
          s10_n = s10 + 3'd1;
        end
      end else begin
        s1_n = s1 + 4'd1;
      end
    end else if (adj_inc) begin
      if (m1 >= 4'd9) begin
        m1_n  = 4'd0;
        m10_n = (m10 >= 3'd5) ? 3'd0 : m10 + 3'd1;
      end else begin
        m1_n = m1 + 4'd1;
      end
    end
  end

  // Blink phase lives only while ADJ persists; leaving ADJ clears it.
  always_comb begin
    bp_n = 1'b0;
    if (state == ADJ && state_n == ADJ) bp_n = bp ^ tick2Hz;
  end

  always_ff @(posedge clkDis) begin
    if (rst) begin
      state    <= RUN;
      m10      <= 3'd0;
      m1       <= 4'd0;
      s10      <= 3'd0;
      s1       <= 4'd0;
      bp       <= 1'b0;
      blankMin <= 1'b0;
      blankSec <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_n;
      m10      <= m10_n;
      m1       <= m1_n;
      s10      <= s10_n;
      s1       <= s1_n;
      bp       <= bp_n;
      blankMin <= (state_n == ADJ) && !selS && bp_n;
      blankSec <= (state_n == ADJ) && selS && bp_n;
      wrap     <= wrap_n;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: counting, rollover, pause, adjust and reset cases
// with hand-computed expected digits, modes and blank masks.
`timescale 1ns/1ps

module tb_stopwatch_counter;

  logic       clkDis = 1'b0;
  logic       rst, pause, tick1Hz, tick2Hz, adj, sel;
  logic [2:0] m10, s10;
  logic [3:0] m1, s1;
  logic [1:0] mode;
  logic       blankMin, blankSec, wrap;

  int total = 0;
  int bad   = 0;
  int wrap_cnt = 0;
  int wc;
  int n;

  stopwatch_counter dut (
    .clkDis  (clkDis),
    .rst     (rst),
    .pause   (pause),
    .tick1Hz (tick1Hz),
    .tick2Hz (tick2Hz),
    .adj     (adj),
    .sel     (sel),
    .m10     (m10),
    .m1      (m1),
    .s10     (s10),
    .s1      (s1),
    .mode    (mode),
    .blankMin(blankMin),
    .blankSec(blankSec),
    .wrap    (wrap)
  );

  always #5 clkDis = ~clkDis;

  always @(negedge clkDis) if (wrap === 1'b1) wrap_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected time as packed BCD nibbles MM:SS.
  task automatic check_time(input string tag, input int mm, input int ss);
    int obs, exp;
    obs = {16'd0, 1'b0, m10, m1, 1'b0, s10, s1};
    exp = ((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10);
    check(tag, obs, exp);
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clkDis);
  endtask

  task automatic t1(input int k);
    tick1Hz = 1'b1;
    cyc(k);
    tick1Hz = 1'b0;
  endtask

  task automatic t2(input int k);
    tick2Hz = 1'b1;
    cyc(k);
    tick2Hz = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; tick1Hz = 1'b0; tick2Hz = 1'b0; adj = 1'b0; sel = 1'b0;
    cyc(2);
    check_time("reset_time", 0, 0);
    check("reset_mode", mode, 0);
    check("reset_blank", {blankMin, blankSec}, 0);
    check("reset_wrap", wrap, 0);
    rst = 1'b0;
    cyc(1);

    // 75 seconds of RUN counting.
    wrap_cnt = 0;
    t1(75);
    check_time("run_75", 1, 15);
    check("run_mode", mode, 0);
    check("run_no_wrap", wrap_cnt, 0);

    // Rollover 59:59 -> 00:00.
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
    t1(3598);
    check_time("pre_5958", 59, 58);
    t1(1);
    check_time("at_5959", 59, 59);
    check("wrap_low_5959", wrap, 0);
    t1(1);
    check_time("rollover", 0, 0);
    check("wrap_high", wrap, 1);
    cyc(1);
    check("wrap_one_cycle", wrap, 0);
    check("wrap_count", wrap_cnt, 1);

    // Pause freezes digits against both ticks.
    t1(754);
    check_time("pre_1234", 12, 34);
    pause = 1'b1;
    cyc(1);
    check("pause_mode", mode, 2);
    tick1Hz = 1'b1; tick2Hz = 1'b1;
    cyc(10);
    tick1Hz = 1'b0; tick2Hz = 1'b0;
    check_time("pause_hold", 12, 34);
    check("pause_mode_hold", mode, 2);
    pause = 1'b0;
    cyc(1);
    check("unpause_mode", mode, 0);
    t1(1);
    check_time("unpause_count", 12, 35);

    // Adjust minutes from 58:10.
    t1(2735);
    check_time("pre_5810", 58, 10);
    adj = 1'b1; sel = 1'b0;
    cyc(2);
    check("adj_latency_2", mode, 0);
    cyc(1);
    check("adj_latency_3", mode, 1);
    wc = wrap_cnt;
    t2(1);
    check_time("adj_min_1", 59, 10);
    check("blink_min_1", {blankMin, blankSec}, 2'b10);
    t2(1);
    check_time("adj_min_2", 0, 10);
    check("blink_min_2", {blankMin, blankSec}, 2'b00);
    t2(1);
    check_time("adj_min_3", 1, 10);
    check("blink_min_3", {blankMin, blankSec}, 2'b10);
    check("adj_no_wrap", wrap_cnt, wc);

    // Reset during ADJ with bp=1.
    rst = 1'b1;
    cyc(1);
    check_time("adj_reset_time", 0, 0);
    check("adj_reset_blank", {blankMin, blankSec}, 0);
    check("adj_reset_mode", mode, 0);
    rst = 1'b0;
    n = 0;
    while (mode !== 2'b01 && n < 6) begin
      cyc(1);
      n++;
    end
    check("adj_reenter", mode, 1);

    // Adjust seconds at 05:59: field wraps without carry, tick1Hz ignored.
    sel = 1'b1; cyc(2);
    t2(59);
    check_time("adj_sec_59", 0, 59);
    sel = 1'b0; cyc(2);
    t2(5);
    check_time("adj_pre_0559", 5, 59);
    sel = 1'b1; cyc(2);
    tick1Hz = 1'b1; tick2Hz = 1'b1;
    cyc(1);
    tick1Hz = 1'b0; tick2Hz = 1'b0;
    check_time("adj_sec_wrap", 5, 0);
    check("blink_sec", {blankMin, blankSec}, 2'b01);
    check("adj_sec_no_wrap", wrap_cnt, wc);

    // Tick in the cycle pause rises still counts in RUN.
    adj = 1'b0;
    cyc(3);
    check("back_to_run", mode, 0);
    check("run_blank", {blankMin, blankSec}, 0);
    pause = 1'b1; tick1Hz = 1'b1;
    cyc(1);
    tick1Hz = 1'b0;
    check_time("pause_edge_tick", 5, 1);
    check("pause_edge_mode", mode, 2);
    pause = 1'b0;
    cyc(1);

    // Tick during reset is dropped.
    rst = 1'b1; tick1Hz = 1'b1;
    cyc(1);
    rst = 1'b0; tick1Hz = 1'b0;
    check_time("reset_drops_tick", 0, 0);
    t1(1);
    check_time("after_reset_tick", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
